// File: rtl/lcd_bus_cycle_pkg.sv
// Shared types, command constants and 1 MHz timing defaults for the LCD write engine.
package lcd_pkg;

  typedef enum logic [2:0] {
    POWERUP = 3'd0,
    IDLE    = 3'd1,
    SETUP   = 3'd2,
    EN_HI   = 3'd3,
    HOLD    = 3'd4,
    WAIT    = 3'd5
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  localparam int DEF_T_POWERUP    = 15000;
  localparam int DEF_T_SETUP      = 1;
  localparam int DEF_T_EN_HIGH    = 1;
  localparam int DEF_T_CMD_WAIT   = 40;
  localparam int DEF_T_CLEAR_WAIT = 1600;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and both Return Home encodings (0x02/0x03) need the long wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == 6'd0) && (data != 8'h00);
  endfunction

endpackage

// File: rtl/lcd_bus_cycle_if.sv
// Upstream byte handshake between the command/data controller and the bus-cycle engine.
interface lcd_bus_cycle_if;
  logic       in_valid;
  logic       in_rs;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;

  modport master (output in_valid, in_rs, in_data, input in_ready, busy);
  modport slave  (input in_valid, in_rs, in_data, output in_ready, busy);
endinterface

// File: rtl/lcd_bus_cycle_delay_counter.sv
// Loadable down-counter timing every engine state; saturates at zero.
module lcd_delay_counter #(
  parameter int WIDTH       = 14,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             done
);

  // Count register: reload on request, otherwise decrement down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= WIDTH'(RESET_VALUE);
    end else if (load) begin
      value <= load_value;
    end else if (value != {WIDTH{1'b0}}) begin
      value <= value - WIDTH'(1);
    end else begin
      value <= value;
    end
  end

  assign done = (value == {WIDTH{1'b0}});

endmodule

// File: rtl/lcd_bus_cycle.sv
// HD44780 physical write engine: one byte per handshake, full setup/enable/hold/exec-wait cycle.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int T_POWERUP    = DEF_T_POWERUP,
  parameter int T_SETUP      = DEF_T_SETUP,
  parameter int T_EN_HIGH    = DEF_T_EN_HIGH,
  parameter int T_CMD_WAIT   = DEF_T_CMD_WAIT,
  parameter int T_CLEAR_WAIT = DEF_T_CLEAR_WAIT
) (
  input  logic           clk,
  input  logic           rst,
  lcd_bus_cycle_if.slave bus,
  output logic [7:0]     lcd_db,
  output logic           lcd_rs,
  output logic           lcd_en,
  output logic           lcd_rw
);

  localparam int T_MAX = max_int(max_int(max_int(T_POWERUP, T_SETUP),
                                         max_int(T_EN_HIGH, T_CMD_WAIT)), T_CLEAR_WAIT);
  localparam int CW    = $clog2(T_MAX + 1);
  typedef logic [CW-1:0] cnt_t;

  lcd_state_e state_r;
  lcd_state_e state_next_s;
  logic       load_s;
  logic       done_s;
  logic       transfer_s;
  logic       in_ready_r;
  logic       rs_r;
  logic [7:0] data_r;
  cnt_t       load_value_s;
  cnt_t       count_unused_s;

  assign transfer_s = bus.in_valid && in_ready_r;

  // Reset itself stands in for the POWERUP entry edge, so one cycle less is preloaded.
  lcd_delay_counter #(
    .WIDTH       (CW),
    .RESET_VALUE (T_POWERUP - 2)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .load_value (load_value_s),
    .value      (count_unused_s),
    .done       (done_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= POWERUP;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state selection and counter reload on every state entry.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      POWERUP: if (done_s) state_next_s = IDLE;  else state_next_s = POWERUP;
      IDLE:    if (transfer_s) state_next_s = SETUP; else state_next_s = IDLE;
      SETUP:   if (done_s) state_next_s = EN_HI; else state_next_s = SETUP;
      EN_HI:   if (done_s) state_next_s = HOLD;  else state_next_s = EN_HI;
      HOLD:    state_next_s = WAIT;
      WAIT:    if (done_s) state_next_s = IDLE;  else state_next_s = WAIT;
      default: state_next_s = POWERUP;
    endcase
  end

  // Duration of the state being entered, minus one.
  always_comb begin
    load_s       = (state_next_s != state_r);
    load_value_s = cnt_t'(0);
    case (state_next_s)
      SETUP:   load_value_s = cnt_t'(T_SETUP - 1);
      EN_HI:   load_value_s = cnt_t'(T_EN_HIGH - 1);
      WAIT: begin
        if (is_long_cmd(rs_r, data_r)) begin
          load_value_s = cnt_t'(T_CLEAR_WAIT - 1);
        end else begin
          load_value_s = cnt_t'(T_CMD_WAIT - 1);
        end
      end
      default: load_value_s = cnt_t'(0);
    endcase
  end

  // Byte capture, handshake readiness and registered LCD pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_r       <= 1'b0;
      data_r     <= 8'h00;
      in_ready_r <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_db     <= 8'h00;
      lcd_en     <= 1'b0;
    end else begin
      if (transfer_s) begin
        rs_r   <= bus.in_rs;
        data_r <= bus.in_data;
      end else begin
        rs_r   <= rs_r;
        data_r <= data_r;
      end
      in_ready_r <= (state_r == IDLE) && !transfer_s;
      lcd_en     <= (state_r == EN_HI);
      if ((state_r != IDLE) && (state_r != POWERUP)) begin
        lcd_rs <= rs_r;
        lcd_db <= data_r;
      end else begin
        lcd_rs <= lcd_rs;
        lcd_db <= lcd_db;
      end
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.busy     = ~in_ready_r;
  assign lcd_rw       = 1'b0;

endmodule

// File: tb/tb_lcd_bus_cycle.sv
// Randomized bench for lcd_bus_cycle against a timeline model built from the cycle rules.
module tb_lcd_bus_cycle;

  localparam int TP = 15000;
  localparam int TS = 1;
  localparam int TE = 1;
  localparam int TC = 40;
  localparam int TL = 1600;

  logic clk;
  logic rst;
  logic [7:0] lcd_db, lcd_db2;
  logic lcd_rs, lcd_en, lcd_rw, lcd_rs2, lcd_en2, lcd_rw2;

  int checks = 0;
  int errors = 0;

  lcd_bus_cycle_if bus ();
  lcd_bus_cycle_if bus2 ();

  lcd_bus_cycle dut (
    .clk(clk), .rst(rst), .bus(bus),
    .lcd_db(lcd_db), .lcd_rs(lcd_rs), .lcd_en(lcd_en), .lcd_rw(lcd_rw)
  );

  lcd_bus_cycle #(
    .T_POWERUP(10), .T_SETUP(2), .T_EN_HIGH(3), .T_CMD_WAIT(5), .T_CLEAR_WAIT(20)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .lcd_db(lcd_db2), .lcd_rs(lcd_rs2), .lcd_en(lcd_en2), .lcd_rw(lcd_rw2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wait_for(input logic rs, input logic [7:0] d);
    if (rs == 1'b0 && d >= 8'd1 && d <= 8'd3) return TL;
    return TC;
  endfunction

  // Reference timeline: cyc = edges since reset release, k = last accept edge.
  int cyc, ready_at, k;
  logic [7:0] pend_db, old_db;
  logic pend_rs, old_rs;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0; ready_at <= TP; k <= -1000000;
      pend_db <= 8'h00; old_db <= 8'h00; pend_rs <= 1'b0; old_rs <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (bus.in_valid && cyc >= ready_at) begin
        k        <= cyc + 1;
        ready_at <= cyc + 1 + TS + TE + 2 + wait_for(bus.in_rs, bus.in_data);
        old_db   <= pend_db;
        old_rs   <= pend_rs;
        pend_db  <= bus.in_data;
        pend_rs  <= bus.in_rs;
      end
    end
  end

  always @(negedge clk) begin
    logic er, ee, ers;
    logic [7:0] edb;
    er  = (cyc >= ready_at);
    ee  = (cyc >= k + 1 + TS) && (cyc <= k + TS + TE);
    ers = (cyc >= k + 1) ? pend_rs : old_rs;
    edb = (cyc >= k + 1) ? pend_db : old_db;
    check("pins", 32'({bus.in_ready, bus.busy, lcd_en, lcd_rs, lcd_db, lcd_rw}),
          32'({er, ~er, ee, ers, edb, 1'b0}));
  end

  task automatic count_powerup();
    int n;
    n = 0;
    while (n < 20000) begin
      @(posedge clk); #1;
      n++;
      if (bus.in_ready === 1'b1) break;
    end
    check("powerup_len", 32'(n), 32'(TP));
  endtask

  task automatic write_byte(input logic rs, input logic [7:0] d);
    int n, lat, en_first, en_len;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 3000) begin
      @(negedge clk); n++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("ready_timeout", 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.in_valid = 1'b1; bus.in_rs = rs; bus.in_data = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_rs = ~rs; bus.in_data = ~d;
    check("no_back_to_back", 32'(bus.in_ready), 32'd0);
    lat = 0; en_first = 0; en_len = 0;
    while (lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check("db_valid", 32'({lcd_rs, lcd_db}), 32'({rs, d}));
      if (lcd_en === 1'b1) begin
        if (en_len == 0) en_first = lat;
        en_len++;
      end
      if (bus.in_ready === 1'b1) break;
    end
    check("en_first", 32'(en_first), 32'(TS + 1));
    check("en_len", 32'(en_len), 32'(TE));
    check("ready_latency", 32'(lat), 32'(TS + TE + 2 + wait_for(rs, d)));
  endtask

  initial begin
    int n, lat, en_first, en_len;
    bit seen;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_rs = 1'b0; bus.in_data = 8'h00;
    bus2.in_valid = 1'b0; bus2.in_rs = 1'b0; bus2.in_data = 8'h00;
    #2;
    check("reset_pins", 32'({bus.in_ready, bus.busy, lcd_en, lcd_rs, lcd_db, lcd_rw}), 32'h800);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    count_powerup();

    write_byte(1'b1, 8'h41);
    write_byte(1'b0, 8'h01);
    write_byte(1'b1, 8'h01);
    write_byte(1'b0, 8'h03);
    write_byte(1'b0, 8'h00);
    write_byte(1'b0, 8'h04);

    // Valid held mostly high with data changing every cycle.
    repeat (6000) begin
      @(negedge clk);
      bus.in_valid = ($urandom_range(0, 7) != 0);
      bus.in_rs    = 1'($urandom_range(0, 1));
      bus.in_data  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;

    // Asynchronous reset during the enable pulse.
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 3000) begin
      @(negedge clk); n++;
    end
    bus.in_valid = 1'b1; bus.in_rs = 1'b1; bus.in_data = 8'h5a;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lcd_en === 1'b1) begin seen = 1'b1; break; end
    end
    check("en_seen_before_rst", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1 check("en_async_drop", 32'(lcd_en), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    count_powerup();

    // Overridden-timing instance.
    @(negedge clk);
    check("dut2_ready", 32'(bus2.in_ready), 32'd1);
    bus2.in_valid = 1'b1; bus2.in_rs = 1'b0; bus2.in_data = 8'h38;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    check("dut2_no_back_to_back", 32'(bus2.in_ready), 32'd0);
    lat = 0; en_first = 0; en_len = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lcd_en2 === 1'b1) begin
        if (en_len == 0) en_first = lat;
        en_len++;
      end
      if (bus2.in_ready === 1'b1) break;
    end
    check("dut2_en_first", 32'(en_first), 32'd3);
    check("dut2_en_len", 32'(en_len), 32'd3);
    check("dut2_ready_latency", 32'(lat), 32'd12);
    check("dut2_db", 32'({lcd_rs2, lcd_db2, lcd_rw2}), 32'({1'b0, 8'h38, 1'b0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_cycle.md
# lcd_bus_cycle

Physical-bus write engine for the HD44780-style character LCD. It sits directly downstream of the LCD command/data controller and accepts one byte at a time, with its RS flag, over a valid/ready handshake. For each byte it generates a complete write cycle on the LCD pins: setup, enable pulse, hold, then the controller execution wait. It runs on the 1 MHz system clock, so 1 cycle = 1 µs.

## Interface
- T_POWERUP, 15000: cycles held busy after reset before the first byte is accepted (15 ms)
- T_SETUP, 1: cycles RS/DB are stable before lcd_en rises; must be ≥1
- T_EN_HIGH, 1: cycles lcd_en is high; must be ≥1
- T_CMD_WAIT, 40: execution wait after an ordinary command or data byte (≥37 µs)
- T_CLEAR_WAIT, 1600: execution wait after Clear Display or Return Home (≥1.52 ms)
- clk  in  1  1 MHz system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream presents a byte
- in_rs  in  1  0 = instruction, 1 = character data
- in_data  in  8  byte to write
- in_ready  out  1  engine can accept a byte this cycle
- busy  out  1  engine is in power-up or a write cycle; equals !in_ready
- lcd_db  out  8  LCD data bus
- lcd_rs  out  1  LCD register select
- lcd_en  out  1  LCD enable strobe
- lcd_rw  out  1  LCD read/write; tied to 0 (write only)

## Operation
- Transfer occurs on a rising edge where in_valid && in_ready. in_rs/in_data are captured into registers at that edge; later input changes have no effect on the cycle in progress.
- States and transitions:
  - POWERUP: counter counts T_POWERUP cycles, then → IDLE.
  - IDLE: in_ready=1; on transfer → SETUP.
  - SETUP: T_SETUP cycles, then → EN_HI.
  - EN_HI: T_EN_HIGH cycles, then → HOLD.
  - HOLD: 1 cycle, then → WAIT.
  - WAIT: W cycles, then → IDLE.
- Wait selection: W = T_CLEAR_WAIT if in_rs==0 and in_data[7:2]==0 and in_data!=0 (Clear 0x01, Home 0x02/0x03). Otherwise W = T_CMD_WAIT, including rs=1 bytes whose value is 0x01–0x03.
- lcd_rs/lcd_db are driven from the captured registers from SETUP through the end of WAIT; they keep their last value in IDLE.
- lcd_en=1 only in EN_HI. All pin outputs are registered, with no combinational path from the inputs.
- in_valid during any non-IDLE state is ignored. Bytes are not queued; upstream must hold the byte until in_ready.
- A byte of 0x00 with rs=0 is a legal no-op command and uses T_CMD_WAIT.

## Timing
- Reset values: lcd_db=0x00, lcd_rs=0, lcd_en=0, lcd_rw=0, in_ready=0, busy=1, state=POWERUP.
- rst asserted mid-cycle drops lcd_en immediately (asynchronous) and restarts the full power-up wait.
- in_ready first rises T_POWERUP cycles after rst deasserts.
- For a transfer at edge k:
  - lcd_rs/lcd_db are valid from edge k+1.
  - lcd_en is high for edges k+1+T_SETUP through k+T_SETUP+T_EN_HIGH.
  - in_ready re-rises at edge k+T_SETUP+T_EN_HIGH+2+W.
- Minimum byte spacing with defaults: 44 cycles (ordinary) and 1604 cycles (clear/home).
- The counter is a single down-counter sized to $clog2(max timing parameter + 1); 14 bits with defaults. Its load value is the state duration minus 1.
- in_ready is low during the cycle after a transfer, so no back-to-back accept is possible.

## Structure
- Shared package lcd_pkg holds:
  - the state enum (POWERUP, IDLE, SETUP, EN_HI, HOLD, WAIT)
  - constants LCD_CMD_CLEAR=8'h01 and LCD_CMD_HOME=8'h02
  - default timing values for a 1 MHz clock
- One sub-module, lcd_delay_counter: a loadable down-counter with load, value and done (value==0) outputs. The FSM reloads it on every state entry.

## Test plan
- Reset release: in_ready stays 0 for exactly 15000 cycles, then goes to 1; all pins read 0 until then.
- Write rs=1, 0x41 at edge k: lcd_rs=1 and lcd_db=0x41 from k+1; lcd_en high only at k+2; in_ready returns at k+44.
- Write rs=0, 0x01: lcd_en pulse identical to the previous case; in_ready returns at k+1604. rs=1, 0x01 returns at k+44.
- Hold in_valid continuously with changing in_data: exactly one byte is accepted per cycle window. lcd_db never changes between SETUP and the end of WAIT; each write takes the byte present at its acceptance edge.
- Assert rst while lcd_en=1: lcd_en falls without waiting for a clock edge and the power-up wait restarts from the full 15000 cycles.
- Parameter override T_SETUP=2, T_EN_HIGH=3, T_CMD_WAIT=5: lcd_en is high at k+3..k+5 and in_ready returns at k+12.
